// File: rtl/shop_pkg.sv
// Shared definitions for the checkout ledger: default widths, FSM state codes, saturation helper.
package shop_pkg;

  localparam int W_WIDTH_DEF    = 4;
  localparam int P_WIDTH_DEF    = 4;
  localparam int CNT_WIDTH_DEF  = 8;
  localparam int SUM_WIDTH_DEF  = 16;
  localparam int HIST_DEPTH_DEF = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_ACC  = 2'd2;

  // Largest unsigned value of a given width; widths above 32 clamp to 32 ones.
  function automatic logic [31:0] sat_max(input int width);
    return (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
  endfunction

endpackage

// File: rtl/shop_mul.sv
// Sequential shift-add multiplier: one multiplier bit per cycle, LSB first, W_WIDTH steps.
// done_o is high during the final step; prod_o holds the full product after that edge.
module shop_mul #(
  parameter int W_WIDTH = 4,
  parameter int P_WIDTH = 4
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       start_i,
  input  logic                       abort_i,
  input  logic [W_WIDTH-1:0]         mplier_i,
  input  logic [P_WIDTH-1:0]         mcand_i,
  output logic                       done_o,
  output logic [W_WIDTH+P_WIDTH-1:0] prod_o
);

  localparam int PW = W_WIDTH + P_WIDTH;
  localparam int CW = $clog2(W_WIDTH + 1);

  logic          run_q, run_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] mcand_q, mcand_d;
  logic [W_WIDTH-1:0] mplier_q, mplier_d;
  logic [PW-1:0] acc_q, acc_d;

  always_comb begin
    run_d    = run_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    if (abort_i) begin
      run_d = 1'b0;
    end else if (start_i) begin
      run_d    = 1'b1;
      cnt_d    = CW'(W_WIDTH);
      mcand_d  = PW'(mcand_i);
      mplier_d = mplier_i;
      acc_d    = '0;
    end else if (run_q) begin
      if (mplier_q[0]) acc_d = acc_q + mcand_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) run_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      run_q    <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else begin
      run_q    <= run_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
    end
  end

  assign done_o = run_q && (cnt_q == CW'(1));
  assign prod_o = acc_q;

endmodule

// File: rtl/shop_ledger.sv
// Checkout accumulator: cal multiplies weight*per, commits W_WIDTH+1 edges later into a saturating total.
// Define SHOP_LEDGER_VOID_EN to build the LIFO history and the void (undo) path.
module shop_ledger
  import shop_pkg::*;
#(
  parameter int W_WIDTH    = W_WIDTH_DEF,
  parameter int P_WIDTH    = P_WIDTH_DEF,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF,
  parameter int SUM_WIDTH  = SUM_WIDTH_DEF,
  parameter int HIST_DEPTH = HIST_DEPTH_DEF
) (
  input  logic                       clk100mhz_i,
  input  logic                       reset_i,
  input  logic                       cal_i,
  input  logic                       clr_i,
  input  logic                       void_i,
  input  logic [W_WIDTH-1:0]         weight_i,
  input  logic [P_WIDTH-1:0]         per_i,
  output logic [W_WIDTH+P_WIDTH-1:0] price_o,
  output logic [CNT_WIDTH-1:0]       times_o,
  output logic [SUM_WIDTH-1:0]       sum_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       overflow_o,
  output logic                       void_err_o,
  output logic                       state_cal_o,
  output logic                       state_reset_o
);

  localparam int PW = W_WIDTH + P_WIDTH;
  localparam logic [SUM_WIDTH-1:0] SUM_MAX = SUM_WIDTH'(sat_max(SUM_WIDTH));
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(sat_max(CNT_WIDTH));

  logic [1:0]           state_q, state_d;
  logic [PW-1:0]        price_q, price_d;
  logic [SUM_WIDTH-1:0] sum_q, sum_d;
  logic [CNT_WIDTH-1:0] times_q, times_d;
  logic ovf_q, ovf_d, done_q, done_d, verr_q, verr_d;
  logic scal_q, scal_d, srst_q, srst_d;
  logic mul_start, mul_done;
  logic [PW-1:0]        mul_prod;
  logic [SUM_WIDTH:0]   sum_ext;

  shop_mul #(.W_WIDTH(W_WIDTH), .P_WIDTH(P_WIDTH)) u_mul (
    .clk_i    (clk100mhz_i),
    .reset_i  (reset_i),
    .start_i  (mul_start),
    .abort_i  (clr_i),
    .mplier_i (weight_i),
    .mcand_i  (per_i),
    .done_o   (mul_done),
    .prod_o   (mul_prod)
  );

  assign sum_ext = {1'b0, sum_q} + (SUM_WIDTH+1)'(mul_prod);

`ifdef SHOP_LEDGER_VOID_EN
  localparam int HC = $clog2(HIST_DEPTH + 1);
  logic [PW-1:0] hist_q [HIST_DEPTH];
  logic [HC-1:0] hcnt_q;
  logic          hist_push, hist_pop;

  // Newest entry lives at index 0; a push into a full buffer drops the oldest off the end.
  always_ff @(posedge clk100mhz_i) begin
    if (!reset_i || clr_i) begin
      hcnt_q <= '0;
      for (int i = 0; i < HIST_DEPTH; i++) hist_q[i] <= '0;
    end else if (hist_push) begin
      hist_q[0] <= mul_prod;
      for (int i = 1; i < HIST_DEPTH; i++) hist_q[i] <= hist_q[i-1];
      if (hcnt_q != HC'(HIST_DEPTH)) hcnt_q <= hcnt_q + HC'(1);
    end else if (hist_pop) begin
      for (int i = 0; i < HIST_DEPTH - 1; i++) hist_q[i] <= hist_q[i+1];
      hist_q[HIST_DEPTH-1] <= '0;
      hcnt_q <= hcnt_q - HC'(1);
    end
  end
`else
  logic unused_void;
  assign unused_void = void_i ^ HIST_DEPTH[0];
`endif

  always_comb begin
    state_d   = state_q;
    price_d   = price_q;
    sum_d     = sum_q;
    times_d   = times_q;
    ovf_d     = ovf_q;
    scal_d    = scal_q;
    srst_d    = srst_q;
    done_d    = 1'b0;
    verr_d    = 1'b0;
    mul_start = 1'b0;
`ifdef SHOP_LEDGER_VOID_EN
    hist_push = 1'b0;
    hist_pop  = 1'b0;
`endif
    if (clr_i) begin
      state_d = ST_IDLE;
      price_d = '0;
      sum_d   = '0;
      times_d = '0;
      ovf_d   = 1'b0;
      scal_d  = 1'b0;
      srst_d  = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
`ifdef SHOP_LEDGER_VOID_EN
          // A saturated total no longer reflects the history, so undo is refused.
          if (void_i) begin
            if (hcnt_q == '0 || ovf_q) begin
              verr_d = 1'b1;
            end else begin
              hist_pop = 1'b1;
              sum_d    = sum_q - SUM_WIDTH'(hist_q[0]);
              times_d  = times_q - CNT_WIDTH'(1);
              price_d  = '0;
              done_d   = 1'b1;
            end
          end else
`endif
          if (cal_i) begin
            mul_start = 1'b1;
            state_d   = ST_MUL;
          end
        end
        ST_MUL: if (mul_done) state_d = ST_ACC;
        ST_ACC: begin
          price_d = mul_prod;
          if (sum_ext > {1'b0, SUM_MAX}) begin
            sum_d = SUM_MAX;
            ovf_d = 1'b1;
          end else begin
            sum_d = sum_ext[SUM_WIDTH-1:0];
          end
          if (times_q == CNT_MAX) ovf_d = 1'b1;
          else times_d = times_q + CNT_WIDTH'(1);
`ifdef SHOP_LEDGER_VOID_EN
          hist_push = 1'b1;
`endif
          done_d  = 1'b1;
          scal_d  = 1'b1;
          srst_d  = 1'b0;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk100mhz_i) begin
    if (!reset_i) begin
      state_q <= ST_IDLE;
      price_q <= '0;
      sum_q   <= '0;
      times_q <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      verr_q  <= 1'b0;
      scal_q  <= 1'b0;
      srst_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      price_q <= price_d;
      sum_q   <= sum_d;
      times_q <= times_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
      verr_q  <= verr_d;
      scal_q  <= scal_d;
      srst_q  <= srst_d;
    end
  end

  assign price_o       = price_q;
  assign times_o       = times_q;
  assign sum_o         = sum_q;
  assign busy_o        = (state_q != ST_IDLE);
  assign done_o        = done_q;
  assign overflow_o    = ovf_q;
  assign void_err_o    = verr_q;
  assign state_cal_o   = scal_q;
  assign state_reset_o = srst_q;

endmodule

// File: tb/tb_shop_ledger.sv
// Bench for shop_ledger: a default-width instance and a narrow (8-bit sum, 3-bit count) instance share stimulus.
module tb_shop_ledger;

  localparam int WW = 4;
  localparam int PWD = 4;
  localparam int PW = WW + PWD;
  localparam int SW0 = 16;
  localparam int CW0 = 8;
  localparam int SW1 = 8;
  localparam int CW1 = 3;
  localparam int HD = 4;
`ifdef SHOP_LEDGER_VOID_EN
  localparam bit VOID_EN = 1'b1;
`else
  localparam bit VOID_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n, cal, clr, vd;
  logic [WW-1:0]  weight;
  logic [PWD-1:0] per;
  logic [PW-1:0]  price0, price1;
  logic [CW0-1:0] times0;
  logic [CW1-1:0] times1;
  logic [SW0-1:0] sum0;
  logic [SW1-1:0] sum1;
  logic busy0, busy1, done0, done1, ovf0, ovf1, verr0, verr1;
  logic scal0, scal1, srst0, srst1;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: per-instance totals, shared display flags, newest-first history queues.
  int m_sum[2], m_times[2], m_price[2];
  bit m_ovf[2];
  bit m_scal, m_srst;
  bit e_done[2], e_err[2];
  int hq0[$];
  int hq1[$];

  always #5 clk = ~clk;

  shop_ledger #(.W_WIDTH(WW), .P_WIDTH(PWD), .CNT_WIDTH(CW0), .SUM_WIDTH(SW0), .HIST_DEPTH(HD)) u_dut (
    .clk100mhz_i(clk), .reset_i(rst_n), .cal_i(cal), .clr_i(clr), .void_i(vd),
    .weight_i(weight), .per_i(per), .price_o(price0), .times_o(times0), .sum_o(sum0),
    .busy_o(busy0), .done_o(done0), .overflow_o(ovf0), .void_err_o(verr0),
    .state_cal_o(scal0), .state_reset_o(srst0)
  );

  shop_ledger #(.W_WIDTH(WW), .P_WIDTH(PWD), .CNT_WIDTH(CW1), .SUM_WIDTH(SW1), .HIST_DEPTH(HD)) u_sat (
    .clk100mhz_i(clk), .reset_i(rst_n), .cal_i(cal), .clr_i(clr), .void_i(vd),
    .weight_i(weight), .per_i(per), .price_o(price1), .times_o(times1), .sum_o(sum1),
    .busy_o(busy1), .done_o(done1), .overflow_o(ovf1), .void_err_o(verr1),
    .state_cal_o(scal1), .state_reset_o(srst1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void model_clear();
    for (int k = 0; k < 2; k++) begin
      m_sum[k] = 0; m_times[k] = 0; m_price[k] = 0; m_ovf[k] = 1'b0;
    end
    hq0.delete();
    hq1.delete();
    m_scal = 1'b0;
    m_srst = 1'b1;
  endfunction

  function automatic void model_commit(input int p);
    for (int k = 0; k < 2; k++) begin
      int smax;
      int cmax;
      smax = (k == 0) ? (1 << SW0) - 1 : (1 << SW1) - 1;
      cmax = (k == 0) ? (1 << CW0) - 1 : (1 << CW1) - 1;
      m_price[k] = p;
      if (m_sum[k] + p > smax) begin
        m_sum[k] = smax;
        m_ovf[k] = 1'b1;
      end else begin
        m_sum[k] = m_sum[k] + p;
      end
      if (m_times[k] + 1 > cmax) m_ovf[k] = 1'b1;
      else m_times[k] = m_times[k] + 1;
    end
    hq0.push_front(p);
    if (hq0.size() > HD) void'(hq0.pop_back());
    hq1.push_front(p);
    if (hq1.size() > HD) void'(hq1.pop_back());
    m_scal = 1'b1;
    m_srst = 1'b0;
  endfunction

  function automatic void model_void();
    for (int k = 0; k < 2; k++) begin
      int sz;
      int e;
      e_done[k] = 1'b0;
      e_err[k]  = 1'b0;
      sz = (k == 0) ? hq0.size() : hq1.size();
      if (VOID_EN) begin
        if (sz == 0 || m_ovf[k]) begin
          e_err[k] = 1'b1;
        end else begin
          if (k == 0) e = hq0.pop_front();
          else e = hq1.pop_front();
          m_sum[k]   = m_sum[k] - e;
          m_times[k] = m_times[k] - 1;
          m_price[k] = 0;
          e_done[k]  = 1'b1;
        end
      end
    end
  endfunction

  task automatic check_all(input string tag);
    chk($sformatf("%s.price0", tag), 32'(price0), m_price[0]);
    chk($sformatf("%s.sum0", tag),   32'(sum0),   m_sum[0]);
    chk($sformatf("%s.times0", tag), 32'(times0), m_times[0]);
    chk($sformatf("%s.ovf0", tag),   32'(ovf0),   32'(m_ovf[0]));
    chk($sformatf("%s.price1", tag), 32'(price1), m_price[1]);
    chk($sformatf("%s.sum1", tag),   32'(sum1),   m_sum[1]);
    chk($sformatf("%s.times1", tag), 32'(times1), m_times[1]);
    chk($sformatf("%s.ovf1", tag),   32'(ovf1),   32'(m_ovf[1]));
    chk($sformatf("%s.busy", tag),   32'({busy0, busy1}), 32'(0));
    chk($sformatf("%s.scal", tag),   32'({scal0, scal1}), 32'({m_scal, m_scal}));
    chk($sformatf("%s.srst", tag),   32'({srst0, srst1}), 32'({m_srst, m_srst}));
  endtask

  task automatic do_cal(input int w, input int p, input bit poke);
    int lat;
    bit seen;
    weight = WW'(w);
    per    = PWD'(p);
    cal    = 1'b1;
    tick();
    cal = 1'b0;
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 30) begin
      if (poke && lat == 1) begin
        cal    = 1'b1;
        weight = WW'($urandom);
        per    = PWD'($urandom);
      end
      tick();
      cal = 1'b0;
      lat++;
      if (done0) seen = 1'b1;
      else chk("cal.busy_during", 32'({busy0, busy1}), 32'(3));
    end
    chk("cal.done_seen", 32'(seen), 32'(1));
    chk("cal.latency", lat, WW + 1);
    chk("cal.done1", 32'(done1), 32'(1));
    model_commit(w * p);
    check_all("cal");
    tick();
    chk("cal.done_pulse", 32'({done0, done1}), 32'(0));
  endtask

  task automatic do_void();
    vd = 1'b1;
    tick();
    vd = 1'b0;
    model_void();
    chk("void.done0", 32'(done0), 32'(e_done[0]));
    chk("void.err0",  32'(verr0), 32'(e_err[0]));
    chk("void.done1", 32'(done1), 32'(e_done[1]));
    chk("void.err1",  32'(verr1), 32'(e_err[1]));
    check_all("void");
    tick();
    chk("void.pulse", 32'({done0, done1, verr0, verr1}), 32'(0));
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    model_clear();
    chk("clr.pulses", 32'({done0, done1, verr0, verr1}), 32'(0));
    check_all("clr");
  endtask

  task automatic abort_mid_mul(input bit use_reset);
    bit seen;
    weight = WW'($urandom_range(1, 15));
    per    = PWD'($urandom_range(1, 15));
    cal    = 1'b1;
    tick();
    cal = 1'b0;
    tick();
    tick();
    if (use_reset) rst_n = 1'b0;
    else clr = 1'b1;
    tick();
    rst_n = 1'b1;
    clr   = 1'b0;
    model_clear();
    chk("abort.done", 32'({done0, done1}), 32'(0));
    check_all("abort");
    seen = 1'b0;
    repeat (8) begin
      tick();
      if (done0 || done1) seen = 1'b1;
    end
    chk("abort.no_late_done", 32'(seen), 32'(0));
    check_all("abort_settle");
  endtask

  initial begin
    rst_n = 1'b0; cal = 1'b1; clr = 1'b1; vd = 1'b0; weight = 4'd3; per = 4'd5;
    tick();
    tick();
    model_clear();
    chk("reset.pulses", 32'({done0, done1, verr0, verr1}), 32'(0));
    check_all("reset");
    rst_n = 1'b1; cal = 1'b0; clr = 1'b0;
    tick();

    do_cal(3, 5, 1'b0);
    do_cal(15, 15, 1'b1);
    do_cal(15, 15, 1'b0);
    repeat (4) do_void();
    do_clr();

    for (int i = 1; i <= 5; i++) do_cal(1, i, 1'b0);
    repeat (5) do_void();
    do_clr();

    for (int i = 0; i < 8; i++) do_cal(1, 1, 1'b0);
    do_void();
    do_clr();

    abort_mid_mul(1'b0);
    abort_mid_mul(1'b1);
    do_cal(7, 9, 1'b0);

    for (int it = 0; it < 60; it++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r <= 5) do_cal(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      else if (r <= 8) do_void();
      else do_clr();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/shop_ledger.md
# shop_ledger

Parametrised checkout accumulator; successor of the fixed 4-bit shop calculator. Each debounced `cal` pulse multiplies `weight` by unit price `per` with a sequential shift-add unit, then adds the product into a running transaction total and counts items. Optional void (undo) of recent items, saturating arithmetic with sticky overflow, and status flags for the seven-segment display driver. Sits between the key debouncers and `segMsg` in the top level.

## Interface
- `W_WIDTH`, 4, weight width
- `P_WIDTH`, 4, unit-price width
- `CNT_WIDTH`, 8, item-counter width
- `SUM_WIDTH`, 16, total width; must be ≥ W_WIDTH+P_WIDTH
- `HIST_DEPTH`, 4, void history entries (only with void feature)
- `clk100mhz` in 1: the single clock
- `reset` in 1: synchronous, active-low; all state cleared on the edge where low
- `cal` in 1: one-cycle pulse, add current item
- `clr` in 1: one-cycle pulse, clear transaction
- `void` in 1: one-cycle pulse, remove last item
- `weight` in W_WIDTH; `per` in P_WIDTH: operands, sampled on the accepting edge
- `price` out W_WIDTH+P_WIDTH: last committed product
- `times` out CNT_WIDTH: items in transaction
- `sum` out SUM_WIDTH: transaction total
- `busy` out 1; `done` out 1 (one-cycle pulse per commit)
- `overflow` out 1: sticky, sum or times saturated
- `void_err` out 1: one-cycle pulse, void refused
- `state_cal`, `state_reset` out 1: display mode flags

## Operation
- FSM: IDLE, MUL, ACC. Reset → IDLE, all outputs 0 except `state_reset`=1.
- IDLE + `cal`: latch weight/per, clear partial product, → MUL.
- MUL: one multiplier bit per cycle, LSB first, W_WIDTH cycles, → ACC.
- ACC: `price`←product; `sum`←min(sum+price, 2^SUM_WIDTH−1); `times`←min(times+1, 2^CNT_WIDTH−1); any saturation sets `overflow`; push price to history; `done`=1 next cycle; `state_cal`=1, `state_reset`=0; → IDLE.
- `clr` (any state): sum, times, price, overflow, history ← 0; `state_reset`=1, `state_cal`=0; aborts MUL/ACC without commit; → IDLE.
- Priority in one cycle: reset > clr > void > cal. `cal` or `void` while busy ignored (not queued).
- Void (IDLE only): if history empty or `overflow`=1 → `void_err` pulse, no change. Else pop newest entry, `sum`−=entry, `times`−=1, `price`←0, `done` pulses.
- History is LIFO; push when full discards oldest entry.
- Product never overflows its own width; only sum/times saturate.

## Timing
- `cal` sampled at edge E0; MUL steps at E1..E_W (W=W_WIDTH); commit at E_{W+1}. Latency W_WIDTH+1 cycles; outputs and `done` valid after E_{W+1}.
- `busy` high from after E0 until after E_{W+1}; next `cal` accepted at E_{W+1}+1 or later... i.e. first edge with `busy`=0.
- Void and clr complete in one edge; `void_err`/`done` are single-cycle.
- Reset low mid-MUL: no commit, all cleared on that edge.

## Configuration
- `SHOP_LEDGER_VOID_EN` defined: history buffer and void logic built as above.
- Undefined: no history storage; `void` ignored; `void_err` tied 0; HIST_DEPTH unused.

## Structure
- Shared package `shop_pkg`: FSM state enum, default widths, saturation-max helper function.
- One sub-module `shop_mul`: sequential shift-add multiplier with start/done; ledger instantiates it and owns accumulation, history, flags.

## Test plan
- Defaults; weight=3, per=5, cal → after 5 cycles price=15, sum=15, times=1, done pulse, state_cal=1.
- Then weight=15, per=15, cal → price=225, sum=240, times=2; second cal during busy ignored (times stays 2).
- SUM_WIDTH=8; items 15 then 225 then 225 → sum=255, overflow=1, times=3; void → void_err pulse, sum unchanged.
- Void enabled; items 15, 225; void → sum=15, times=1; void → sum=0, times=0; void → void_err.
- clr asserted 2 cycles into MUL → no done, sum=0, times=0, state_reset=1, busy=0 next cycle.
- reset low with cal and clr high → all outputs 0, state_reset=1; cal after release proceeds normally.
